ahb_master_arbiter: RTL and testbench

//  Shares the single AHB-Lite master port of the RV32E subsystem between the instruction-fetch and data-memory requesters.

---
 rtl/ahb_master_arbiter_if.sv | 56 +++++
 rtl/ahb_master_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_arbiter_if
//  Description : Bundles the core-side imem/dmem request ports and the
//                AHB-Lite master port of the fetch/data arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_master_arbiter_if;
  // Instruction-fetch requester
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_err;
  // Data-memory requester
  logic        dmem_req;
  logic        dmem_we;
  logic [1:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_err;
  // AHB-Lite master port
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  // Arbiter view: consumes requests and bus responses, drives everything else
  modport master (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata, imem_err,
    input  dmem_req, dmem_we, dmem_size, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata, dmem_err,
    output HADDR, HTRANS, HWRITE, HSIZE, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  // Environment view: requesters plus bus fabric
  modport slave (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata, imem_err,
    output dmem_req, dmem_we, dmem_size, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata, dmem_err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface
`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_arbiter
//  Description : Shares one AHB-Lite master port between instruction fetch
//                and data memory. Data has priority; fetch wins once after
//                STARVE_LIMIT consecutive data grants made while it waited.
//                Non-pipelined: IDLE -> ADDR -> DATA per transfer, with
//                misaligned/illegal data requests faulted without a bus cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_master_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  wire logic           HCLK,
  input  wire logic           HRESET,
  ahb_master_arbiter_if.master bus
);

  localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
  localparam logic [1:0] c_HTRANS_IDLE  = 2'b00;
  localparam logic [1:0] c_HTRANS_NSEQ  = 2'b10;
  localparam logic [3:0] c_HPROT_FETCH  = 4'b0010;
  localparam logic [3:0] c_HPROT_DATA   = 4'b0011;
  localparam logic [2:0] c_HSIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Latched transfer attributes; these are the AHB address-phase outputs
  logic [31:0] r_addr;
  logic        r_we;
  logic [2:0]  r_size;
  logic [3:0]  r_prot;
  logic [31:0] r_wdata;
  logic        r_owner_dmem;
  logic [3:0]  r_cnt;

  logic        w_grant_imem;
  logic        w_grant_dmem;
  logic        w_misaligned;
  logic        w_start_bus;
  logic        w_imem_ready;
  logic        w_imem_err;
  logic [31:0] w_imem_rdata;
  logic        w_dmem_ready;
  logic        w_dmem_err;
  logic [31:0] w_dmem_rdata;
  logic        w_unused_bits;

  // Fetch wins only when data is absent or fetch has been starved long enough
  assign w_grant_imem = bus.imem_req && (!bus.dmem_req || (r_cnt == c_STARVE_LIMIT));
  assign w_grant_dmem = bus.dmem_req && !w_grant_imem;

  // Illegal size or unaligned half/word data access never reaches the bus
  assign w_misaligned = (bus.dmem_size == 2'd3) ||
                        ((bus.dmem_size == 2'd1) && bus.dmem_addr[0]) ||
                        ((bus.dmem_size == 2'd2) && (bus.dmem_addr[1:0] != 2'b00));

  // Fetch is word-only and HRESP[1] carries no meaning for AHB-Lite
  assign w_unused_bits = ^{bus.imem_addr[1:0], bus.HRESP[1]};

  // State register; reset abandons any transfer in flight
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and requester completion outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_start_bus  = 1'b0;
    w_imem_ready = 1'b0;
    w_imem_err   = 1'b0;
    w_imem_rdata = 32'h0;
    w_dmem_ready = 1'b0;
    w_dmem_err   = 1'b0;
    w_dmem_rdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_dmem && w_misaligned) begin
          w_state_nxt = S_FAULT;
        end else if (w_grant_dmem || w_grant_imem) begin
          w_start_bus = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.HREADY) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        // First ERROR cycle has HREADY=0 and simply waits here
        if (bus.HREADY) begin
          if (r_owner_dmem) begin
            w_dmem_ready = 1'b1;
            w_dmem_err   = bus.HRESP[0];
            w_dmem_rdata = bus.HRDATA;
          end else begin
            w_imem_ready = 1'b1;
            w_imem_err   = bus.HRESP[0];
            w_imem_rdata = bus.HRDATA;
          end
          w_state_nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        w_dmem_ready = 1'b1;
        w_dmem_err   = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture the winner's attributes only when a real bus cycle starts,
  // so HADDR and friends hold their last values through IDLE and FAULT
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_addr       <= 32'h0;
      r_we         <= 1'b0;
      r_size       <= c_HSIZE_WORD;
      r_prot       <= c_HPROT_FETCH;
      r_wdata      <= 32'h0;
      r_owner_dmem <= 1'b0;
    end else if (w_start_bus) begin
      if (w_grant_dmem) begin
        r_addr       <= bus.dmem_addr;
        r_we         <= bus.dmem_we;
        r_size       <= {1'b0, bus.dmem_size};
        r_prot       <= c_HPROT_DATA;
        r_wdata      <= bus.dmem_wdata;
        r_owner_dmem <= 1'b1;
      end else begin
        r_addr       <= {bus.imem_addr[31:2], 2'b00};
        r_we         <= 1'b0;
        r_size       <= c_HSIZE_WORD;
        r_prot       <= c_HPROT_FETCH;
        r_wdata      <= 32'h0;
        r_owner_dmem <= 1'b0;
      end
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_imem || !bus.imem_req) begin
        r_cnt <= 4'd0;
      end else if (w_grant_dmem && (r_cnt < c_STARVE_LIMIT)) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign bus.HADDR      = r_addr;
  assign bus.HTRANS     = (r_state == S_ADDR) ? c_HTRANS_NSEQ : c_HTRANS_IDLE;
  assign bus.HWRITE     = r_we;
  assign bus.HSIZE      = r_size;
  assign bus.HPROT      = r_prot;
  assign bus.HMASTLOCK  = 1'b0;
  assign bus.HWDATA     = r_wdata;

  assign bus.imem_ready = w_imem_ready;
  assign bus.imem_err   = w_imem_err;
  assign bus.imem_rdata = w_imem_rdata;
  assign bus.dmem_ready = w_dmem_ready;
  assign bus.dmem_err   = w_dmem_err;
  assign bus.dmem_rdata = w_dmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_master_arbiter
//  Description : Directed bench for ahb_master_arbiter. Stimulus pushes the
//                expected completion (owner, data, error, cycle) into a queue;
//                a negedge monitor pops and compares on every ready pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_master_arbiter;

  typedef struct {
    bit          owner_dmem;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  logic HCLK;
  logic HRESET;
  int   checks;
  int   errors;
  int   cyc;
  exp_t sb[$];

  ahb_master_arbiter_if bus_if ();

  ahb_master_arbiter #(.STARVE_LIMIT(4)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus_if)
  );

  // 100 MHz bus clock
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Cycle index, advanced on each rising edge
  always @(posedge HCLK) cyc <= cyc + 1;

  // Hard stop if something hangs
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit owner_dmem, input logic [31:0] rdata, input bit err, input int c);
    exp_t e;
    e.owner_dmem = owner_dmem;
    e.rdata      = rdata;
    e.err        = err;
    e.cyc        = c;
    sb.push_back(e);
  endtask

  // Advance to just after the next rising edge (drive point)
  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  // Advance to the next falling edge (sample point)
  task automatic sample();
    @(negedge HCLK);
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest expectation
  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESET && (bus_if.imem_ready || bus_if.dmem_ready)) begin
      if (bus_if.imem_ready && bus_if.dmem_ready) begin
        check("dual_ready", 32'd1, 32'd0);
      end
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("owner_dmem", {31'd0, bus_if.dmem_ready}, {31'd0, e.owner_dmem});
        check("ready_cycle", 32'(cyc), 32'(e.cyc));
        if (e.owner_dmem) begin
          check("dmem_rdata", bus_if.dmem_rdata, e.rdata);
          check("dmem_err", {31'd0, bus_if.dmem_err}, {31'd0, e.err});
        end else begin
          check("imem_rdata", bus_if.imem_rdata, e.rdata);
          check("imem_err", {31'd0, bus_if.imem_err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    int n;
    int k;
    checks = 0;
    errors = 0;
    cyc    = 0;
    HRESET = 1'b1;
    bus_if.imem_req   = 1'b0;
    bus_if.imem_addr  = 32'h0;
    bus_if.dmem_req   = 1'b0;
    bus_if.dmem_we    = 1'b0;
    bus_if.dmem_size  = 2'd0;
    bus_if.dmem_addr  = 32'h0;
    bus_if.dmem_wdata = 32'h0;
    bus_if.HRDATA     = 32'h0;
    bus_if.HREADY     = 1'b1;
    bus_if.HRESP      = 2'b00;

    // ---------------- reset state ----------------
    sample();
    check("rst_htrans", {30'd0, bus_if.HTRANS}, 32'h0);
    check("rst_haddr", bus_if.HADDR, 32'h0);
    check("rst_hsize", {29'd0, bus_if.HSIZE}, 32'h2);
    check("rst_hprot", {28'd0, bus_if.HPROT}, 32'h2);
    check("rst_hwdata", bus_if.HWDATA, 32'h0);
    check("rst_hwrite_lock", {30'd0, bus_if.HWRITE, bus_if.HMASTLOCK}, 32'h0);
    check("rst_readies", {30'd0, bus_if.imem_ready, bus_if.dmem_ready}, 32'h0);
    #2 HRESET = 1'b0;

    // ---------------- fetch, zero wait ----------------
    next();
    n = cyc;
    bus_if.imem_req  = 1'b1;
    bus_if.imem_addr = 32'h100;
    bus_if.HRDATA    = 32'h0000_0013;
    push(1'b0, 32'h0000_0013, 1'b0, n + 2);
    sample();
    check("f_c0_htrans", {30'd0, bus_if.HTRANS}, 32'h0);
    next();
    sample();
    check("f_c1_htrans", {30'd0, bus_if.HTRANS}, 32'h2);
    check("f_c1_haddr", bus_if.HADDR, 32'h100);
    check("f_c1_hprot", {28'd0, bus_if.HPROT}, 32'h2);
    check("f_c1_hsize_wr", {28'd0, bus_if.HSIZE, bus_if.HWRITE}, {28'd0, 3'b010, 1'b0});
    next();
    next();
    bus_if.imem_req = 1'b0;
    next();

    // ---------------- data write with two wait states ----------------
    n = cyc;
    bus_if.dmem_req   = 1'b1;
    bus_if.dmem_we    = 1'b1;
    bus_if.dmem_size  = 2'd2;
    bus_if.dmem_addr  = 32'h40;
    bus_if.dmem_wdata = 32'hDEAD_BEEF;
    bus_if.HRDATA     = 32'h0;
    push(1'b1, 32'h0, 1'b0, n + 4);
    next();
    sample();
    check("w_c1_htrans", {30'd0, bus_if.HTRANS}, 32'h2);
    check("w_c1_haddr", bus_if.HADDR, 32'h40);
    check("w_c1_hwrite", {31'd0, bus_if.HWRITE}, 32'h1);
    check("w_c1_hsize", {29'd0, bus_if.HSIZE}, 32'h2);
    check("w_c1_hprot", {28'd0, bus_if.HPROT}, 32'h3);
    for (k = 2; k <= 4; k++) begin
      next();
      bus_if.HREADY = (k == 4);
      sample();
      check("w_hwdata", bus_if.HWDATA, 32'hDEAD_BEEF);
      check("w_data_htrans", {30'd0, bus_if.HTRANS}, 32'h0);
    end
    next();
    bus_if.dmem_req = 1'b0;
    bus_if.dmem_we  = 1'b0;
    next();

    // ---------------- data read with two-cycle ERROR ----------------
    n = cyc;
    bus_if.dmem_req  = 1'b1;
    bus_if.dmem_size = 2'd2;
    bus_if.dmem_addr = 32'h80;
    push(1'b1, 32'h0, 1'b1, n + 3);
    next();
    next();
    bus_if.HREADY = 1'b0;
    bus_if.HRESP  = 2'b01;
    next();
    bus_if.HREADY = 1'b1;
    next();
    bus_if.HRESP     = 2'b00;
    n = cyc;
    bus_if.dmem_addr = 32'h84;
    bus_if.HRDATA    = 32'hCAFE_0001;
    push(1'b1, 32'hCAFE_0001, 1'b0, n + 2);
    next();
    next();
    next();
    bus_if.dmem_req = 1'b0;
    next();

    // ---------------- faults: misaligned half, illegal size ----------------
    for (int f = 0; f < 2; f++) begin
      n = cyc;
      bus_if.dmem_req  = 1'b1;
      bus_if.dmem_size = (f == 0) ? 2'd1 : 2'd3;
      bus_if.dmem_addr = (f == 0) ? 32'h41 : 32'h44;
      bus_if.HRDATA    = 32'h5555_AAAA;
      push(1'b1, 32'h0, 1'b1, n + 1);
      sample();
      check("fault_c0_htrans", {30'd0, bus_if.HTRANS}, 32'h0);
      next();
      sample();
      check("fault_c1_htrans", {30'd0, bus_if.HTRANS}, 32'h0);
      check("fault_haddr_held", bus_if.HADDR, 32'h84);
      next();
      bus_if.dmem_req = 1'b0;
      next();
    end

    // ---------------- starvation: both held continuously ----------------
    n = cyc;
    bus_if.HRDATA    = 32'h1234_5678;
    bus_if.imem_req  = 1'b1;
    bus_if.imem_addr = 32'h104;
    bus_if.dmem_req  = 1'b1;
    bus_if.dmem_we   = 1'b0;
    bus_if.dmem_size = 2'd2;
    bus_if.dmem_addr = 32'h10;
    for (k = 0; k < 10; k++) begin
      push((k != 4) && (k != 9), 32'h1234_5678, 1'b0, n + 2 + 3 * k);
    end
    for (k = 0; k < 100 && sb.size() != 0; k++) begin
      next();
    end
    check("starve_drained", 32'(sb.size()), 32'h0);
    bus_if.imem_req = 1'b0;
    bus_if.dmem_req = 1'b0;
    next();

    // ---------------- reset mid-transfer ----------------
    bus_if.imem_req  = 1'b1;
    bus_if.imem_addr = 32'h300;
    next();
    bus_if.HREADY = 1'b0;
    sample();
    check("r_addr_phase_htrans", {30'd0, bus_if.HTRANS}, 32'h2);
    #1 HRESET = 1'b1;
    #1;
    check("r_async_htrans", {30'd0, bus_if.HTRANS}, 32'h0);
    check("r_async_haddr", bus_if.HADDR, 32'h0);
    bus_if.imem_req = 1'b0;
    bus_if.HREADY   = 1'b1;
    next();
    sample();
    #2 HRESET = 1'b0;
    next();
    n = cyc;
    bus_if.imem_req  = 1'b1;
    bus_if.imem_addr = 32'h200;
    bus_if.HRDATA    = 32'h0000_0055;
    push(1'b0, 32'h0000_0055, 1'b0, n + 2);
    next();
    next();
    next();
    bus_if.imem_req = 1'b0;
    repeat (4) next();
    check("final_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
